dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: RAM_WORDS, 64, number of 32-bit data RAM words (power of 2, 16..1024).
REQ-002 SHALL have parameter: FIFO_DEPTH, 4, output-port FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: mem_write  input  1  core store strobe, sampled at rising clk.
REQ-006 SHALL have port: addr  input  32  byte address from core ALU result.
REQ-007 SHALL have port: wdata  input  32  store data from core register-file read port 2.
REQ-008 SHALL have port: read_data  output  32  load data returned to core, combinational from addr.
REQ-009 SHALL have port: out_data  output  32  FIFO head word.
REQ-010 SHALL have port: out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts head at rising clk when out_valid.
REQ-012 SHALL have port: leds  output  8  LED register contents.

Function
REQ-013 SHALL decode addr: RAM when addr < RAM_WORDS*4 (word index addr[..:2], addr[1:0] ignored); OUT 0xFFFF_FF00; STATUS 0xFFFF_FF04; LED 0xFFFF_FF08; CYCLE 0xFFFF_FF0C; all else unmapped.
REQ-014 SHALL write wdata to RAM word at rising clk when mem_write and RAM decoded; read is asynchronous, same-cycle write not visible until next cycle.
REQ-015 SHALL push wdata into FIFO at rising clk when mem_write and OUT decoded and push is accepted; OUT reads return 0.
REQ-016 SHALL pop FIFO head at rising clk when out_valid and out_ready.
REQ-017 SHALL accept a push when count < FIFO_DEPTH, or when full and a pop occurs in the same cycle (count unchanged).
REQ-018 SHALL drop a rejected push, leave FIFO unchanged, and set sticky overflow flag.
REQ-019 SHALL return STATUS read as: bit0 full, bit1 empty, bit2 overflow, bits[12:8] count, other bits 0; reflects registered state before the current edge.
REQ-020 SHALL clear overflow on any mem_write to STATUS; a simultaneous rejected push sets it (set wins).
REQ-021 SHALL load LED register from wdata[7:0] on mem_write to LED; LED read returns {24'b0, leds}.
REQ-022 SHALL ignore writes to CYCLE and unmapped addresses; unmapped reads return 0.
REQ-023 SHALL keep FIFO order strictly first-in first-out with pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-024 SHALL, on reset assertion, asynchronously set: FIFO empty (count 0, out_valid 0), overflow 0, leds 0, cycle counter 0.
REQ-025 SHALL NOT clear RAM contents on reset; out_data is don't-care while out_valid is 0.
REQ-026 SHALL discard FIFO contents if reset asserts mid-operation; a push or pop on the deasserting edge is not required to occur.

Configuration
REQ-027 SHALL, with DMEM_CYCLE_CNT_EN defined, include a 32-bit free-running counter incremented every clk, wrapping 0xFFFF_FFFF -> 0, readable at CYCLE.
REQ-028 SHALL, without DMEM_CYCLE_CNT_EN, omit the counter logic and return 0 for CYCLE reads.

Structure
REQ-029 SHALL place address-map constants (OUT, STATUS, LED, CYCLE) and STATUS bit positions in shared package dmem_pkg.
REQ-030 SHALL implement the FIFO as sub-module out_fifo (push, pop, data, count, full, empty).

Verification
REQ-031 SHALL test: store 0xDEADBEEF to 0x0000_0010, load 0x0000_0013 next cycle -> read_data 0xDEADBEEF.
REQ-032 SHALL test: out_ready=0, five stores 1..5 to OUT -> STATUS count 4, full 1, overflow 1; drain -> out_data 1,2,3,4 in order, empty 1.
REQ-033 SHALL test: FIFO full, out_ready=1 and store 9 to OUT same cycle -> head pops, 9 accepted, count stays 4, overflow unchanged.
REQ-034 SHALL test: overflow set, write STATUS -> overflow 0; store 0xA5 to LED -> leds 0xA5, LED read 0x0000_00A5.
REQ-035 SHALL test: reset asserted mid-cycle with count 3 -> out_valid 0 and leds 0 immediately, no clock edge needed.
REQ-036 SHALL test: with DMEM_CYCLE_CNT_EN, two CYCLE reads 10 clocks apart differ by 10; without, read 0; unmapped 0x1000_0000 reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit layout and address decoder for the data-memory responder.
package dmem_pkg;

    localparam logic [31:0] ADDR_OUT    = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_FF08;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FF0C;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_CNT_LSB   = 8;
    localparam int ST_CNT_W     = 5;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_OUT,
        RGN_STATUS,
        RGN_LED,
        RGN_CYCLE
    } region_e;

    function automatic region_e decode_addr(input logic [31:0] a, input logic [31:0] ram_bytes);
        if (a < ram_bytes)           return RGN_RAM;
        else if (a == ADDR_OUT)      return RGN_OUT;
        else if (a == ADDR_STATUS)   return RGN_STATUS;
        else if (a == ADDR_LED)      return RGN_LED;
        else if (a == ADDR_CYCLE)    return RGN_CYCLE;
        else                         return RGN_NONE;
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Output-port FIFO. The caller only asserts push when it may be accepted (not full, or popping).
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus memory-mapped OUT FIFO, STATUS, LED and CYCLE registers.
// Optional free-running cycle counter enabled by defining DMEM_CYCLE_CNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  leds
);

    localparam int IW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_e rgn;
    assign rgn = decode_addr(addr, 32'(RAM_WORDS * 4));

    logic [31:0]   ram_q [RAM_WORDS];
    logic [IW-1:0] ram_idx;
    assign ram_idx = addr[IW+1:2];

    always_ff @(posedge clk) begin
        if (mem_write && rgn == RGN_RAM) ram_q[ram_idx] <= wdata;
    end

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, push_req, push_rej;
    logic [CW-1:0] fifo_count;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign fifo_pop  = out_ready && !fifo_empty;
    assign push_req  = mem_write && rgn == RGN_OUT;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign push_rej  = push_req && !fifo_push;

    out_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (wdata),
        .head_data (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    logic       ovf_q, ovf_d;
    logic [7:0] leds_q, leds_d;

    always_comb begin
        ovf_d  = ovf_q;
        leds_d = leds_q;
        if (mem_write && rgn == RGN_STATUS) ovf_d = 1'b0;
        if (push_rej) ovf_d = 1'b1;
        if (mem_write && rgn == RGN_LED) leds_d = wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            leds_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            leds_q <= leds_d;
        end
    end

    logic [31:0] cycle_val;
`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end
    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    logic [31:0] status_word;
    always_comb begin
        status_word                             = '0;
        status_word[ST_FULL_BIT]                = fifo_full;
        status_word[ST_EMPTY_BIT]               = fifo_empty;
        status_word[ST_OVF_BIT]                 = ovf_q;
        status_word[ST_CNT_LSB +: ST_CNT_W]     = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        case (rgn)
            RGN_RAM:    read_data = ram_q[ram_idx];
            RGN_STATUS: read_data = status_word;
            RGN_LED:    read_data = {24'b0, leds_q};
            RGN_CYCLE:  read_data = cycle_val;
            default:    read_data = '0;
        endcase
    end

    assign out_valid = !fifo_empty;
    assign leds      = leds_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised + directed bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

    localparam int RW = 64;
    localparam int FD = 4;
    localparam logic [31:0] A_OUT    = 32'hFFFF_FF00;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
    localparam logic [31:0] A_LED    = 32'hFFFF_FF08;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_UNMAP  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        out_ready = 1'b0;
    logic [31:0] read_data, out_data;
    logic        out_valid;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    dmem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .read_data (read_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .leds      (leds)
    );

    int total = 0;
    int bad = 0;

    // reference model state
    logic [31:0] ram_m [RW];
    logic [31:0] q_m [$];
    logic        ovf_m = 1'b0;
    logic [7:0]  leds_m = '0;
    logic [31:0] cyc_m = '0;

    logic [31:0] last_rd, last_od;
    logic        last_ov;
    logic [7:0]  last_leds;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int n;
        n = q_m.size();
        if (a < RW * 4)        return ram_m[int'(a / 4)];
        if (a == A_STATUS)     return (32'(n) << 8) | (32'(ovf_m) << 2)
                                      | ((n == 0) ? 32'd2 : 32'd0) | ((n == FD) ? 32'd1 : 32'd0);
        if (a == A_LED)        return 32'(leds_m);
`ifdef DMEM_CYCLE_CNT_EN
        if (a == A_CYCLE)      return cyc_m;
`endif
        return 32'd0;
    endfunction

    // One bus transaction: drive, check pre-edge outputs, clock, advance model.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic chk_rd);
        logic pop;
        mem_write = w; addr = a; wdata = d; out_ready = rdy;
        #2;
        last_rd = read_data; last_od = out_data; last_ov = out_valid; last_leds = leds;
        if (chk_rd) check_val("read_data", read_data, model_read(a));
        check_val("out_valid", 32'(out_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) check_val("out_data", out_data, q_m[0]);
        check_val("leds", 32'(leds), 32'(leds_m));
        @(posedge clk);
        pop = rdy && (q_m.size() != 0);
        if (w && a < RW * 4) ram_m[int'(a / 4)] = d;
        if (w && a == A_STATUS) ovf_m = 1'b0;
        if (w && a == A_LED) leds_m = d[7:0];
        if (w && a == A_OUT && q_m.size() == FD && !pop) ovf_m = 1'b1;
        else begin
            if (pop) void'(q_m.pop_front());
            if (w && a == A_OUT) q_m.push_back(d);
        end
        if (pop && !(w && a == A_OUT) && q_m.size() == FD) void'(q_m.pop_front());
        cyc_m = cyc_m + 32'd1;
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1; mem_write = 1'b0; out_ready = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_leds", 32'(leds), 32'd0);
        q_m.delete(); ovf_m = 1'b0; leds_m = '0; cyc_m = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin : main
        logic [31:0] c1, c2, a, d;
        int sel;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < RW; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

        // store then load via unaligned byte address of the same word
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(1'b0, 32'h13, 32'h0, 1'b0, 1'b1);
        check_val("t_ram_load", last_rd, 32'hDEAD_BEEF);

        // overflow with stalled consumer, then drain in order
        for (int k = 1; k <= 5; k++) step(1'b1, A_OUT, 32'(k), 1'b0, 1'b1);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        check_val("t_ovf_status", last_rd, 32'h0000_0405);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, A_UNMAP, 32'h0, 1'b1, 1'b1);
            check_val("t_drain", last_od, 32'(k));
        end
        step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        check_val("t_drained_status", last_rd, 32'h0000_0006);

        // STATUS write clears overflow; LED register
        step(1'b1, A_STATUS, 32'h0, 1'b0, 1'b1);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        check_val("t_ovf_clear", last_rd, 32'h0000_0002);
        step(1'b1, A_LED, 32'h1234_56A5, 1'b0, 1'b1);
        step(1'b0, A_LED, 32'h0, 1'b0, 1'b1);
        check_val("t_led_read", last_rd, 32'h0000_00A5);
        check_val("t_leds", 32'(last_leds), 32'h0000_00A5);

        // push into a full FIFO while the head pops on the same edge
        for (int k = 5; k <= 8; k++) step(1'b1, A_OUT, 32'(k), 1'b0, 1'b1);
        step(1'b1, A_OUT, 32'd9, 1'b1, 1'b1);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        check_val("t_full_pushpop", last_rd, 32'h0000_0401);
        for (int k = 6; k <= 9; k++) begin
            step(1'b0, A_UNMAP, 32'h0, 1'b1, 1'b1);
            check_val("t_drain2", last_od, 32'(k));
        end

        // mid-cycle reset with three entries queued
        for (int k = 0; k < 3; k++) step(1'b1, A_OUT, 32'(100 + k), 1'b0, 1'b1);
        step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        check_val("t_pre_reset_cnt", last_rd, 32'h0000_0300);
        do_reset();
        step(1'b0, A_STATUS, 32'h0, 1'b0, 1'b1);
        check_val("t_post_reset", last_rd, 32'h0000_0002);

        // cycle counter and unmapped reads
        step(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1);
        c1 = last_rd;
        for (int k = 0; k < 9; k++) step(1'b0, A_UNMAP, 32'h0, 1'b0, 1'b1);
        step(1'b0, A_CYCLE, 32'h0, 1'b0, 1'b1);
        c2 = last_rd;
`ifdef DMEM_CYCLE_CNT_EN
        check_val("t_cycle_delta", c2 - c1, 32'd10);
`else
        check_val("t_cycle_zero1", c1, 32'd0);
        check_val("t_cycle_zero2", c2, 32'd0);
`endif
        step(1'b1, A_UNMAP, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b0, A_UNMAP, 32'h0, 1'b0, 1'b1);
        check_val("t_unmapped", last_rd, 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: a = 32'($urandom_range(0, RW * 4 - 1));
                3, 4, 5: a = A_OUT;
                6:       a = A_STATUS;
                7:       a = A_LED;
                8:       a = A_CYCLE;
                default: a = ($urandom_range(0, 1) == 0) ? A_UNMAP : $urandom | 32'h0000_1000;
            endcase
            d = $urandom;
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 2) != 0), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
